// File: rtl/booth_product_accumulator.sv
// Frame accumulator for signed Booth products: sums FRAME_LEN products per frame
// and presents the total with an overflow flag. Define SATURATE_EN for clamping adds.
module booth_product_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int FRAME_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic              oflow_q, oflow_d;

    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  raw_sum;
    logic [ACC_W-1:0]  add_res;
    logic              add_ovf;
    logic              accept;

    assign prod_ext = ACC_W'($signed(in_product));
    assign raw_sum  = acc_q + prod_ext;
    // Same-sign operands yielding an opposite-sign result is the only overflow case.
    assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (raw_sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef SATURATE_EN
    assign add_res = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : raw_sum;
`else
    assign add_res = raw_sum;
`endif

    assign accept = in_valid && in_ready && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            oflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            oflow_q <= oflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        oflow_d = oflow_q;
        case (state_q)
            ACCUM: begin
                if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        sum_d   = add_res;
                        oflow_d = ovf_q | add_ovf;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        acc_d = add_res;
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | add_ovf;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    assign out_sum      = sum_q;
    assign out_overflow = oflow_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed scoreboard bench: defaults, a narrow 8-bit/2-product instance, and a FRAME_LEN=1 instance.
module tb_booth_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [7:0]  prod      [3];
    logic        clr       [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic        out_ovf   [3];
    logic [15:0] sum_a;
    logic [7:0]  sum_b;
    logic [15:0] sum_c;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int d;
        int sum;
        int ovf;
    } res_t;
    res_t sb[$];

    int accw [3] = '{16, 8, 16};
    int flen [3] = '{4, 2, 1};
    int acc_m[3];
    int cnt_m[3];
    int ovf_m[3];

    always #5 clk = ~clk;

    booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .FRAME_LEN(4)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_product(prod[0]), .clr(clr[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum(sum_a), .out_overflow(out_ovf[0]));

    booth_product_accumulator #(.PROD_W(8), .ACC_W(8), .FRAME_LEN(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_product(prod[1]), .clr(clr[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum(sum_b), .out_overflow(out_ovf[1]));

    booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .FRAME_LEN(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_product(prod[2]), .clr(clr[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum(sum_c), .out_overflow(out_ovf[2]));

    function automatic int get_sum(input int d);
        case (d)
            0:       return int'($signed(sum_a));
            1:       return int'($signed(sum_b));
            default: return int'($signed(sum_c));
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear(input int d);
        acc_m[d] = 0;
        cnt_m[d] = 0;
        ovf_m[d] = 0;
    endtask

    // Integer reference: exact sum, then wrap or clamp into the instance's width.
    task automatic model_add(input int d, input int p);
        int w;
        int mx;
        int mn;
        int s;
        w  = accw[d];
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        s  = acc_m[d] + p;
        if (s > mx || s < mn) begin
            ovf_m[d] = 1;
`ifdef SATURATE_EN
            s = (s > mx) ? mx : mn;
`else
            s = (s > mx) ? s - (1 << w) : s + (1 << w);
`endif
        end
        acc_m[d] = s;
        cnt_m[d]++;
        if (cnt_m[d] == flen[d]) begin
            sb.push_back('{d: d, sum: acc_m[d], ovf: ovf_m[d]});
            model_clear(d);
        end
    endtask

    task automatic send(input int d, input int p);
        int pend;
        check("in_ready_before_send", int'(in_ready[d]), 1);
        in_valid[d] = 1'b1;
        prod[d]     = 8'(p);
        pend        = sb.size();
        model_add(d, p);
        step();
        in_valid[d] = 1'b0;
        check("out_valid_after_send", int'(out_valid[d]), (sb.size() > pend) ? 1 : 0);
    endtask

    task automatic take(input int d);
        res_t r;
        check("out_valid_pending", int'(out_valid[d]), 1);
        check("sb_nonempty", sb.size(), (sb.size() > 0) ? sb.size() : 1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check("sb_dut", d, r.d);
            check("out_sum", get_sum(d), r.sum);
            check("out_overflow", int'(out_ovf[d]), r.ovf);
        end
        out_ready[d] = 1'b1;
        step();
        out_ready[d] = 1'b0;
        check("out_valid_after_hs", int'(out_valid[d]), 0);
        check("in_ready_after_hs", int'(in_ready[d]), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            check({tag, "_in_ready"}, int'(in_ready[d]), 1);
            check({tag, "_out_valid"}, int'(out_valid[d]), 0);
            check({tag, "_out_ovf"}, int'(out_ovf[d]), 0);
            check({tag, "_out_sum"}, get_sum(d), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            prod[d]      = '0;
            clr[d]       = 1'b0;
            out_ready[d] = 1'b0;
            model_clear(d);
        end
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: 6 - 12 + 49 - 56 = -13
        send(0, 6);
        send(0, -12);
        send(0, 49);
        send(0, -56);
        check("basic_sum_direct", get_sum(0), -13);

        // Backpressure: product offered while the result is held
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1;
            prod[0]     = 8'd7;
            step();
            check("bp_in_ready", int'(in_ready[0]), 0);
            check("bp_out_valid", int'(out_valid[0]), 1);
            check("bp_sum_stable", get_sum(0), -13);
        end
        take(0);
        in_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) send(0, 7);
        check("bp_next_frame", get_sum(0), 28);
        take(0);

        // Clear drops the partial frame and the same-cycle product
        send(0, 30);
        send(0, 30);
        clr[0]      = 1'b1;
        in_valid[0] = 1'b1;
        prod[0]     = 8'd99;
        step();
        clr[0]      = 1'b0;
        in_valid[0] = 1'b0;
        model_clear(0);
        check("clr_no_output", int'(out_valid[0]), 0);
        send(0, 1);
        send(0, 2);
        send(0, 3);
        send(0, 4);
        check("clr_sum_direct", get_sum(0), 10);
        take(0);

        // Reset mid-frame
        send(0, 5);
        send(0, 5);
        send(0, 5);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_midframe");
        for (int d = 0; d < 3; d++) model_clear(d);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(0, 5);
        check("rst_sum_direct", get_sum(0), 20);
        take(0);

        // Reset while a result is pending discards it
        for (int i = 0; i < 4; i++) send(0, 1);
        check("hold_before_rst", int'(out_valid[0]), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        sb.delete();
        for (int d = 0; d < 3; d++) model_clear(d);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Narrow accumulator overflow cases
        send(1, 64);
        send(1, 64);
`ifdef SATURATE_EN
        check("ovf_pos_direct", get_sum(1), 127);
`else
        check("ovf_pos_direct", get_sum(1), -128);
`endif
        check("ovf_pos_flag", int'(out_ovf[1]), 1);
        take(1);
        send(1, -64);
        send(1, -64);
        take(1);
        send(1, -100);
        send(1, -100);
        check("ovf_neg_flag", int'(out_ovf[1]), 1);
        take(1);
        send(1, 100);
        send(1, -100);
        take(1);

        // Single-product frames with idle gaps
        send(2, -8);
        take(2);
        for (int i = 0; i < 3; i++) step();
        check("gap_idle", int'(out_valid[2]), 0);
        send(2, 64);
        take(2);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
